// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the pipeline status and latch-control signals of the
// hazard controller.
//   master : pipeline side, drives the memory/decode/branch status and
//            perf_clear, and receives the latch controls, PC redirect and counters.
//   slave  : hazard_ctrl itself.
// clk and reset are not part of the interface and stay plain module ports.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             imem_read;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             ex_is_load;
  logic [2:0]       ex_dest;
  logic [2:0]       id_src1;
  logic [2:0]       id_src2;
  logic             id_use1;
  logic             id_use2;
  logic             br_taken;
  logic [15:0]      br_target;
  logic             perf_clear;

  logic             load_pc;
  logic             pc_sel_target;
  logic [15:0]      pc_target;
  logic             load_if_id;
  logic             inject_NOP;
  logic             squash_instr;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp, ex_is_load, ex_dest,
           id_src1, id_src2, id_use1, id_use2, br_taken, br_target, perf_clear,
    input  load_pc, pc_sel_target, pc_target, load_if_id, inject_NOP,
           squash_instr, load_id_ex, load_ex_mem, load_mem_wb, flush_id_ex,
           flush_ex_mem, stall_count, flush_count
  );

  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp, ex_is_load, ex_dest,
           id_src1, id_src2, id_use1, id_use2, br_taken, br_target, perf_clear,
    output load_pc, pc_sel_target, pc_target, load_if_id, inject_NOP,
           squash_instr, load_id_ex, load_ex_mem, load_mem_wb, flush_id_ex,
           flush_ex_mem, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Merges I-/D-memory stalls,
// load-use hazards and MEM-stage taken branches into per-cycle latch loads,
// flushes, IF/ID NOP injection/squash and a PC redirect. Keeps saturating
// stall and flush counters.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   hz     : hazard_ctrl_if.slave (status in, latch controls/counters out)
// Latch controls are combinational from state and inputs; state and
// counters update on clk.
//
// state         | meaning
// --------------+-------------------------------------------------------
// RUN           | normal flow; load-use and fetch stalls evaluated here
// BUBBLE        | extra load-use bubbles still owed (bub_cnt remaining)
// REDIRECT_WAIT | taken branch seen while a fetch was outstanding; the
//               | wrong-path fetch is squashed, target_q waits for imem_resp
module hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);
  typedef enum logic [1:0] {RUN, BUBBLE, REDIRECT_WAIT} state_t;

  state_t           state, state_nxt;
  logic [15:0]      target_q, target_nxt;
  logic [1:0]       bub_cnt, bub_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_inc, flush_inc;
  logic             mem_stall, if_stall, load_use;

  assign mem_stall = hz.dmem_req & ~hz.dmem_resp;
  assign if_stall  = hz.imem_read & ~hz.imem_resp;
  assign load_use  = hz.ex_is_load &
                     ((hz.id_use1 & (hz.ex_dest == hz.id_src1)) |
                      (hz.id_use2 & (hz.ex_dest == hz.id_src2)));

  always_comb begin
    hz.load_pc       = 1'b1;
    hz.pc_sel_target = 1'b0;
    hz.pc_target     = (state == REDIRECT_WAIT) ? target_q : hz.br_target;
    hz.load_if_id    = 1'b1;
    hz.inject_NOP    = 1'b0;
    hz.squash_instr  = 1'b0;
    hz.load_id_ex    = 1'b1;
    hz.load_ex_mem   = 1'b1;
    hz.load_mem_wb   = 1'b1;
    hz.flush_id_ex   = 1'b0;
    hz.flush_ex_mem  = 1'b0;
    state_nxt        = state;
    target_nxt       = target_q;
    bub_nxt          = bub_cnt;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;

    if (reset) begin
      // Clock NOPs into the latches that have no reset of their own.
      hz.load_pc      = 1'b0;
      hz.squash_instr = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_ex_mem = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe freezes; a branch in MEM is re-presented once the access completes.
      hz.load_pc     = 1'b0;
      hz.load_if_id  = 1'b0;
      hz.load_id_ex  = 1'b0;
      hz.load_ex_mem = 1'b0;
      hz.load_mem_wb = 1'b0;
      stall_inc      = 1'b1;
    end else if (state == REDIRECT_WAIT) begin
      hz.load_pc      = 1'b0;
      hz.squash_instr = 1'b1;
      stall_inc       = 1'b1;
      if (hz.imem_resp) begin
        hz.load_pc       = 1'b1;
        hz.pc_sel_target = 1'b1;
        state_nxt        = RUN;
      end
    end else if (hz.br_taken) begin
      hz.flush_id_ex  = 1'b1;
      hz.flush_ex_mem = 1'b1;
      hz.squash_instr = 1'b1;
      flush_inc       = 1'b1;
      bub_nxt         = 2'd0;
      if (if_stall) begin
        // Cannot redirect under an outstanding fetch; park the target.
        hz.load_pc = 1'b0;
        target_nxt = hz.br_target;
        state_nxt  = REDIRECT_WAIT;
      end else begin
        hz.pc_sel_target = 1'b1;
        state_nxt        = RUN;
      end
    end else if (state == BUBBLE) begin
      hz.load_pc    = 1'b0;
      hz.load_if_id = 1'b0;
      hz.inject_NOP = 1'b1;
      stall_inc     = 1'b1;
      bub_nxt       = bub_cnt - 2'd1;
      if (bub_cnt <= 2'd1) begin
        state_nxt = RUN;
      end
    end else if (load_use) begin
      hz.load_pc    = 1'b0;
      hz.load_if_id = 1'b0;
      hz.inject_NOP = 1'b1;
      stall_inc     = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        state_nxt = BUBBLE;
        bub_nxt   = 2'(LOAD_USE_BUBBLES - 1);
      end
    end else if (if_stall) begin
      hz.load_pc    = 1'b0;
      hz.load_if_id = 1'b0;
      hz.inject_NOP = 1'b1;
      stall_inc     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      target_q  <= '0;
      bub_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      target_q <= target_nxt;
      bub_cnt  <= bub_nxt;
      if (hz.perf_clear) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end
    end
  end

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int LUB = 2;

  typedef struct packed {
    logic        reset;
    logic        imem_read;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    logic        ex_is_load;
    logic [2:0]  ex_dest;
    logic [2:0]  id_src1;
    logic [2:0]  id_src2;
    logic        id_use1;
    logic        id_use2;
    logic        br_taken;
    logic [15:0] br_target;
    logic        perf_clear;
  } stim_t;

  typedef struct {
    logic [25:0] ctrl;
    int          stalls;
    int          flushes;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_sat;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  exp_t sb_q[$];

  // reference model state
  bit          pending  = 0;
  logic [15:0] saved    = '0;
  int          bub_left = 0;
  int          stalls   = 0;
  int          flushes  = 0;

  hazard_ctrl_if #(.CNT_W(16)) hz ();
  hazard_ctrl_if #(.CNT_W(4))  hs ();

  hazard_ctrl #(.LOAD_USE_BUBBLES(LUB), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (rst),
    .hz    (hz)
  );

  hazard_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (rst_sat),
    .hz    (hs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.imem_read = 1'b1;
    s.imem_resp = 1'b1;
    return s;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    logic lp, sel, lif, nop, sq, lie, lem, lmw, fie, fem;
    logic [15:0] tgt;
    bit mem_stall, if_stall, hazard, stall_cyc, flush_cyc;
    mem_stall = s.dmem_req && !s.dmem_resp;
    if_stall  = s.imem_read && !s.imem_resp;
    hazard    = s.ex_is_load && ((s.id_use1 && s.ex_dest == s.id_src1) ||
                                 (s.id_use2 && s.ex_dest == s.id_src2));
    lp = 1; sel = 0; lif = 1; nop = 0; sq = 0; lie = 1; lem = 1; lmw = 1; fie = 0; fem = 0;
    tgt = pending ? saved : s.br_target;
    stall_cyc = 0;
    flush_cyc = 0;
    e.stalls  = stalls;
    e.flushes = flushes;
    if (s.reset) begin
      lp = 0; sq = 1; fie = 1; fem = 1;
    end else if (mem_stall) begin
      lp = 0; lif = 0; lie = 0; lem = 0; lmw = 0; stall_cyc = 1;
    end else if (pending) begin
      lp = 0; sq = 1; stall_cyc = 1;
      if (s.imem_resp) begin
        lp = 1; sel = 1; pending = 0;
      end
    end else if (s.br_taken) begin
      fie = 1; fem = 1; sq = 1; flush_cyc = 1; bub_left = 0;
      if (if_stall) begin
        lp = 0; pending = 1; saved = s.br_target;
      end else begin
        sel = 1;
      end
    end else if (bub_left > 0) begin
      lp = 0; lif = 0; nop = 1; stall_cyc = 1; bub_left--;
    end else if (hazard) begin
      lp = 0; lif = 0; nop = 1; stall_cyc = 1; bub_left = LUB - 1;
    end else if (if_stall) begin
      lp = 0; lif = 0; nop = 1; stall_cyc = 1;
    end
    e.ctrl = {lp, sel, tgt, lif, nop, sq, lie, lem, lmw, fie, fem};
    if (s.reset) begin
      pending = 0; bub_left = 0; stalls = 0; flushes = 0;
    end else if (s.perf_clear) begin
      stalls = 0; flushes = 0;
    end else begin
      if (stall_cyc && stalls < 65535) stalls++;
      if (flush_cyc && flushes < 65535) flushes++;
    end
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = s.reset;
    hz.imem_read  = s.imem_read;
    hz.imem_resp  = s.imem_resp;
    hz.dmem_req   = s.dmem_req;
    hz.dmem_resp  = s.dmem_resp;
    hz.ex_is_load = s.ex_is_load;
    hz.ex_dest    = s.ex_dest;
    hz.id_src1    = s.id_src1;
    hz.id_src2    = s.id_src2;
    hz.id_use1    = s.id_use1;
    hz.id_use2    = s.id_use2;
    hz.br_taken   = s.br_taken;
    hz.br_target  = s.br_target;
    hz.perf_clear = s.perf_clear;
    model_step(s, e);
    sb_q.push_back(e);
  endtask

  // monitor: the DUT presents a full control word every cycle
  initial begin
    exp_t        e;
    logic [25:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cyc++;
        act = {hz.load_pc, hz.pc_sel_target, hz.pc_target, hz.load_if_id, hz.inject_NOP,
               hz.squash_instr, hz.load_id_ex, hz.load_ex_mem, hz.load_mem_wb,
               hz.flush_id_ex, hz.flush_ex_mem};
        n_chk++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl cyc %0d: got %h expected %h", cyc, act, e.ctrl);
        end
        n_chk++;
        if ({hz.stall_count, hz.flush_count} !== {16'(e.stalls), 16'(e.flushes)}) begin
          n_fail++;
          $display("FAIL counters cyc %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   cyc, hz.stall_count, hz.flush_count, e.stalls, e.flushes);
        end
      end
    end
  end

  task automatic sat_cycle(input logic r, input logic dreq, input logic ld, input logic clr);
    @(posedge clk);
    #1;
    rst_sat       = r;
    hs.dmem_req   = dreq;
    hs.ex_is_load = ld;
    hs.perf_clear = clr;
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;
    hz.imem_read = 1'b1; hz.imem_resp = 1'b1; hz.dmem_req = 1'b0; hz.dmem_resp = 1'b0;
    hz.ex_is_load = 1'b0; hz.ex_dest = '0; hz.id_src1 = '0; hz.id_src2 = '0;
    hz.id_use1 = 1'b0; hz.id_use2 = 1'b0; hz.br_taken = 1'b0; hz.br_target = '0;
    hz.perf_clear = 1'b0;
    rst_sat = 1'b1;
    hs.imem_read = 1'b1; hs.imem_resp = 1'b1; hs.dmem_req = 1'b0; hs.dmem_resp = 1'b0;
    hs.ex_is_load = 1'b0; hs.ex_dest = 3'd5; hs.id_src1 = 3'd5; hs.id_src2 = 3'd0;
    hs.id_use1 = 1'b1; hs.id_use2 = 1'b0; hs.br_taken = 1'b0; hs.br_target = '0;
    hs.perf_clear = 1'b0;

    // reset
    s = idle_stim(); s.reset = 1'b1;
    repeat (2) drive(s);

    // D-memory stall with a branch held in MEM, then completion
    s = idle_stim(); s.dmem_req = 1; s.br_taken = 1; s.br_target = 16'h1234;
    repeat (4) drive(s);
    s.dmem_resp = 1;
    drive(s);

    // load-use on src2: two bubbles, then free flow
    s = idle_stim(); s.ex_is_load = 1; s.ex_dest = 3'd3; s.id_src2 = 3'd3; s.id_use2 = 1;
    drive(s);
    s.ex_is_load = 0;
    drive(s);
    drive(s);

    // taken branch under an outstanding fetch
    s = idle_stim(); s.br_taken = 1; s.br_target = 16'h3000; s.imem_resp = 0;
    drive(s);
    s.br_taken = 0; s.br_target = 16'h0044;
    repeat (2) drive(s);
    s.imem_resp = 1;
    drive(s);
    drive(idle_stim());

    // taken branch during the bubble
    s = idle_stim(); s.ex_is_load = 1; s.ex_dest = 3'd1; s.id_src1 = 3'd1; s.id_use1 = 1;
    drive(s);
    s = idle_stim(); s.br_taken = 1; s.br_target = 16'h0A0A;
    drive(s);
    drive(idle_stim());

    // plain fetch stall
    s = idle_stim(); s.imem_resp = 0;
    drive(s);
    drive(idle_stim());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.imem_read  = ($urandom_range(0, 99) < 70);
      s.imem_resp  = ($urandom_range(0, 99) < 60);
      s.dmem_req   = ($urandom_range(0, 99) < 25);
      s.dmem_resp  = ($urandom_range(0, 99) < 50);
      s.ex_is_load = ($urandom_range(0, 99) < 40);
      s.ex_dest    = 3'($urandom_range(0, 3));
      s.id_src1    = 3'($urandom_range(0, 3));
      s.id_src2    = 3'($urandom_range(0, 3));
      s.id_use1    = 1'($urandom_range(0, 1));
      s.id_use2    = 1'($urandom_range(0, 1));
      s.br_taken   = ($urandom_range(0, 99) < 15);
      s.br_target  = 16'($urandom_range(0, 65535));
      s.perf_clear = ($urandom_range(0, 99) < 3);
      drive(s);
    end
    drive(idle_stim());
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // narrow-counter instance: saturation, clear, three-bubble load-use
    sat_cycle(1, 0, 0, 0);
    sat_cycle(1, 0, 0, 0);
    chk("sat_reset_count", 32'(hs.stall_count), 32'd0);
    chk("sat_reset_squash", 32'(hs.squash_instr), 32'd1);
    repeat (14) sat_cycle(0, 1, 0, 0);
    chk("sat_stall_load_id_ex", 32'(hs.load_id_ex), 32'd0);
    sat_cycle(0, 0, 0, 0);
    chk("sat_count_E", 32'(hs.stall_count), 32'hE);
    repeat (3) sat_cycle(0, 1, 0, 0);
    sat_cycle(0, 0, 0, 0);
    chk("sat_count_hold_F", 32'(hs.stall_count), 32'hF);
    sat_cycle(0, 1, 0, 1);
    sat_cycle(0, 0, 0, 0);
    chk("sat_clear_wins", 32'(hs.stall_count), 32'd0);
    sat_cycle(0, 0, 1, 0);
    chk("lub3_bubble1", 32'({hs.inject_NOP, hs.load_if_id, hs.load_id_ex}), 32'b101);
    sat_cycle(0, 0, 0, 0);
    chk("lub3_bubble2", 32'({hs.inject_NOP, hs.load_if_id}), 32'b10);
    sat_cycle(0, 0, 0, 0);
    chk("lub3_bubble3", 32'({hs.inject_NOP, hs.load_if_id}), 32'b10);
    sat_cycle(0, 0, 0, 0);
    chk("lub3_release", 32'({hs.inject_NOP, hs.load_if_id, hs.load_pc}), 32'b011);
    chk("lub3_stall_count", 32'(hs.stall_count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
